// File: rtl/div32_seq_pkg.sv
// div32_seq_pkg
// Types and constants shared by the divider top and its step sub-module.
// Pulls in div32_defs.vh so the enum encodings track the shared defines.
package div32_seq_pkg;

`include "div32_defs.vh"

    localparam int W    = `DIV32_W;
    localparam int ITER = `DIV32_ITER;

    typedef enum logic [1:0] {
        S_IDLE = `DIV32_S_IDLE,
        S_RUN  = `DIV32_S_RUN,
        S_DONE = `DIV32_S_DONE
    } state_t;

    // Two's-complement negate, used for magnitude and sign fix-up.
    function automatic logic [W-1:0] neg32(input logic [W-1:0] x);
        return ~x + {{(W-1){1'b0}}, 1'b1};
    endfunction

endpackage

// File: rtl/div32_defs.vh
// div32_defs.vh
// Shared constants for the sequential 32-bit divider:
//   DIV32_S_IDLE / DIV32_S_RUN / DIV32_S_DONE : FSM state encodings
//   DIV32_W    : datapath width
//   DIV32_ITER : restoring iterations per division (one quotient bit each)
`ifndef DIV32_DEFS_VH
`define DIV32_DEFS_VH

`define DIV32_S_IDLE 2'd0
`define DIV32_S_RUN  2'd1
`define DIV32_S_DONE 2'd2
`define DIV32_W      32
`define DIV32_ITER   32

`endif

// File: rtl/div32_step.sv
// div32_step
// One combinational restoring-division iteration.
//   i_pr      : current partial remainder (always < divisor)
//   i_dvd_msb : dividend bit shifted into the partial remainder
//   i_divisor : divisor magnitude
//   o_pr      : next partial remainder
//   o_qbit    : quotient bit produced by this iteration
module div32_step
    import div32_seq_pkg::*;
(
    input  logic [W-1:0] i_pr,
    input  logic         i_dvd_msb,
    input  logic [W-1:0] i_divisor,
    output logic [W-1:0] o_pr,
    output logic         o_qbit
);

    // The shifted remainder {pr, msb} is < 2*divisor, so a 33-bit difference
    // has bit 32 set exactly when the subtraction would go negative.
    logic [W:0] w_trial;

    assign w_trial = {i_pr, i_dvd_msb} - {1'b0, i_divisor};
    assign o_qbit  = ~w_trial[W];
    assign o_pr    = w_trial[W] ? {i_pr[W-2:0], i_dvd_msb} : w_trial[W-1:0];

endmodule

// File: rtl/div32_seq.sv
// div32_seq
// Sequential 32-bit restoring divider, one quotient bit per clock.
//   clk, rst_n            : clock, asynchronous active-low reset
//   in_valid / in_ready   : operand handshake (ready only in IDLE)
//   op1, op2, sgn         : dividend, divisor, signed request
//   out_valid / out_ready : result handshake
//   quo, rem, dbz         : quotient, remainder, divide-by-zero flag
// Build option: define DIV32_SIGNED_EN to honour sgn (two's complement
// division); otherwise sgn is ignored and all division is unsigned.
module div32_seq
    import div32_seq_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] op1,
    input  logic [W-1:0] op2,
    input  logic         sgn,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] quo,
    output logic [W-1:0] rem,
    output logic         dbz
);

    state_t         r_state, w_state_nxt;
    logic [4:0]     r_cnt;
    logic [W-1:0]   r_pr, r_dvd, r_dsr;
    logic [W-1:0]   r_quo, r_rem;
    logic           r_dbz, r_out_valid;

    logic           w_accept, w_last, w_qbit;
    logic [W-1:0]   w_pr_nxt, w_q_raw, w_quo_fin, w_rem_fin;
    logic [W-1:0]   w_op1_mag, w_op2_mag;

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = r_out_valid;
    assign quo       = r_quo;
    assign rem       = r_rem;
    assign dbz       = r_dbz;

    assign w_accept  = in_valid & in_ready;
    assign w_last    = (r_cnt == 5'(ITER - 1));
    assign w_q_raw   = {r_dvd[W-2:0], w_qbit};

`ifdef DIV32_SIGNED_EN
    logic r_neg_q, r_neg_r;
    logic w_op1_neg, w_op2_neg;

    assign w_op1_neg = sgn & op1[W-1];
    assign w_op2_neg = sgn & op2[W-1];
    assign w_op1_mag = w_op1_neg ? neg32(op1) : op1;
    assign w_op2_mag = w_op2_neg ? neg32(op2) : op2;
    // Quotient negative when signs differ; remainder follows the dividend.
    assign w_quo_fin = r_neg_q ? neg32(w_q_raw)  : w_q_raw;
    assign w_rem_fin = r_neg_r ? neg32(w_pr_nxt) : w_pr_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
        end else if (w_accept) begin
            r_neg_q <= w_op1_neg ^ w_op2_neg;
            r_neg_r <= w_op1_neg;
        end
    end
`else
    logic w_unused_sgn;

    assign w_unused_sgn = sgn;
    assign w_op1_mag    = op1;
    assign w_op2_mag    = op2;
    assign w_quo_fin    = w_q_raw;
    assign w_rem_fin    = w_pr_nxt;
`endif

    div32_step u_step (
        .i_pr      (r_pr),
        .i_dvd_msb (r_dvd[W-1]),
        .i_divisor (r_dsr),
        .o_pr      (w_pr_nxt),
        .o_qbit    (w_qbit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (w_accept) w_state_nxt = (op2 == '0) ? S_DONE : S_RUN;
            S_RUN:  if (w_last)   w_state_nxt = S_DONE;
            S_DONE: if (r_out_valid && out_ready) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Results load on entry to DONE; out_valid follows one cycle later and
    // drops on the same edge the handshake returns the FSM to IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt       <= '0;
            r_pr        <= '0;
            r_dvd       <= '0;
            r_dsr       <= '0;
            r_quo       <= '0;
            r_rem       <= '0;
            r_dbz       <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= (r_state == S_DONE) && !(r_out_valid && out_ready);
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_cnt <= '0;
                        r_pr  <= '0;
                        r_dvd <= w_op1_mag;
                        r_dsr <= w_op2_mag;
                        if (op2 == '0) begin
                            r_quo <= '1;
                            r_rem <= op1;
                            r_dbz <= 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    r_pr  <= w_pr_nxt;
                    r_dvd <= w_q_raw;
                    r_cnt <= r_cnt + 5'd1;
                    if (w_last) begin
                        r_quo <= w_quo_fin;
                        r_rem <= w_rem_fin;
                        r_dbz <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
